vid_bus_arbiter: RTL and testbench

VID_BUS_ARBITER -- requirements
Module: vid_bus_arbiter

---
 rtl/vid_bus_arbiter_pkg.sv | 13 +
 rtl/vid_bus_arbiter_starve_timer.sv | 27 ++
 rtl/vid_bus_arbiter.sv | 110 +++++++++++
 tb/tb_vid_bus_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_bus_arbiter_pkg.sv
// Shared video package: bus-owner state encoding used by the arbiter
// and visible on its o_owner port.
package vid_bus_arbiter_pkg;

   localparam int OWNER_W = 2;

   typedef enum logic [OWNER_W-1:0] {
      OWNER_IDLE = 2'b00,
      OWNER_A    = 2'b01,
      OWNER_B    = 2'b10
   } owner_e;

endpackage

// File: rtl/vid_bus_arbiter_starve_timer.sv
// Saturating wait counter: counts cycles a request goes unserved and
// flags once it reaches all-ones.
module starve_timer #(
   parameter int LG = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic count_en,
   input  logic clear,
   output logic saturated
);

   logic [LG-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (count_en && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign saturated = (r_cnt == '1);

endmodule

// File: rtl/vid_bus_arbiter.sv
// Two-master Wishbone arbiter: video fetch (A) has priority, display
// writer (B) wins the next idle decision once it has starved.
module vid_bus_arbiter
   import vid_bus_arbiter_pkg::*;
#(
   parameter int AW       = 24,
   parameter int DW       = 32,
   parameter int LGSTARVE = 6
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_a_cyc,
   input  logic              i_a_stb,
   input  logic              i_a_we,
   input  logic [AW-1:0]     i_a_addr,
   input  logic [DW-1:0]     i_a_data,
   input  logic [DW/8-1:0]   i_a_sel,
   output logic              o_a_ack,
   output logic              o_a_stall,
   output logic              o_a_err,
   input  logic              i_b_cyc,
   input  logic              i_b_stb,
   input  logic              i_b_we,
   input  logic [AW-1:0]     i_b_addr,
   input  logic [DW-1:0]     i_b_data,
   input  logic [DW/8-1:0]   i_b_sel,
   output logic              o_b_ack,
   output logic              o_b_stall,
   output logic              o_b_err,
   output logic              o_cyc,
   output logic              o_stb,
   output logic              o_we,
   output logic [AW-1:0]     o_addr,
   output logic [DW-1:0]     o_data,
   output logic [DW/8-1:0]   o_sel,
   input  logic              i_ack,
   input  logic              i_stall,
   input  logic              i_err,
   output logic [OWNER_W-1:0] o_owner
);

   owner_e r_state;
   owner_e w_next;
   logic   w_own_a;
   logic   w_own_b;
   logic   w_starve_flag;

   // B accrues wait time whenever it asks for the bus but does not hold it
   starve_timer #(
      .LG (LGSTARVE)
   ) u_starve (
      .clk       (i_clk),
      .reset     (i_reset),
      .count_en  (i_b_cyc && (r_state != OWNER_B)),
      .clear     (!i_b_cyc || (r_state == OWNER_B)),
      .saturated (w_starve_flag)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= OWNER_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         OWNER_IDLE: begin
            if (i_a_cyc && !w_starve_flag) begin
               w_next = OWNER_A;
            end else if (i_b_cyc && (!i_a_cyc || w_starve_flag)) begin
               w_next = OWNER_B;
            end
         end
         OWNER_A: if (!i_a_cyc) w_next = OWNER_IDLE;
         OWNER_B: if (!i_b_cyc) w_next = OWNER_IDLE;
         default: w_next = OWNER_IDLE;
      endcase
   end

   assign w_own_a = (r_state == OWNER_A);
   assign w_own_b = (r_state == OWNER_B);

   // Owner's cyc is passed straight through so a dropped cyc aborts immediately
   always_comb begin
      o_cyc     = (w_own_a && i_a_cyc) || (w_own_b && i_b_cyc);
      o_stb     = (w_own_a && i_a_stb) || (w_own_b && i_b_stb);
      o_we      = i_a_we;
      o_addr    = i_a_addr;
      o_data    = i_a_data;
      o_sel     = i_a_sel;
      if (w_own_b) begin
         o_we   = i_b_we;
         o_addr = i_b_addr;
         o_data = i_b_data;
         o_sel  = i_b_sel;
      end
      o_a_ack   = w_own_a && i_ack;
      o_a_err   = w_own_a && i_err;
      o_a_stall = w_own_a ? i_stall : 1'b1;
      o_b_ack   = w_own_b && i_ack;
      o_b_err   = w_own_b && i_err;
      o_b_stall = w_own_b ? i_stall : 1'b1;
   end

   assign o_owner = r_state;

endmodule

// File: tb/tb_vid_bus_arbiter.sv
// Self-checking bench for vid_bus_arbiter: directed vector table, hand
// sequences for starvation/abort/reset, then random traffic vs a model.
module tb_vid_bus_arbiter;

   localparam int AW   = 24;
   localparam int DW   = 32;
   localparam int LG   = 6;
   localparam int MAXW = (1 << LG) - 1;

   logic i_clk = 1'b0;
   logic i_reset;
   logic i_a_cyc, i_a_stb, i_a_we, i_b_cyc, i_b_stb, i_b_we;
   logic [AW-1:0] i_a_addr, i_b_addr;
   logic [DW-1:0] i_a_data, i_b_data;
   logic [DW/8-1:0] i_a_sel, i_b_sel;
   logic i_ack, i_stall, i_err;
   logic o_a_ack, o_a_stall, o_a_err, o_b_ack, o_b_stall, o_b_err;
   logic o_cyc, o_stb, o_we;
   logic [AW-1:0] o_addr;
   logic [DW-1:0] o_data;
   logic [DW/8-1:0] o_sel;
   logic [1:0] o_owner;

   int n_checks = 0;
   int n_err    = 0;

   always #5 i_clk = ~i_clk;

   vid_bus_arbiter #(.AW(AW), .DW(DW), .LGSTARVE(LG)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we),
      .i_a_addr(i_a_addr), .i_a_data(i_a_data), .i_a_sel(i_a_sel),
      .o_a_ack(o_a_ack), .o_a_stall(o_a_stall), .o_a_err(o_a_err),
      .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we),
      .i_b_addr(i_b_addr), .i_b_data(i_b_data), .i_b_sel(i_b_sel),
      .o_b_ack(o_b_ack), .o_b_stall(o_b_stall), .o_b_err(o_b_err),
      .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_addr(o_addr),
      .o_data(o_data), .o_sel(o_sel),
      .i_ack(i_ack), .i_stall(i_stall), .i_err(i_err),
      .o_owner(o_owner)
   );

   // Output bundle: {owner, cyc, stb, we, addr, data, sel, a_ack, a_stall, a_err, b_ack, b_stall, b_err}
   logic [70:0] w_act;
   assign w_act = {o_owner, o_cyc, o_stb, o_we, o_addr, o_data, o_sel,
                   o_a_ack, o_a_stall, o_a_err, o_b_ack, o_b_stall, o_b_err};

   // Reference model: owner as 0/1/2 and B's unserved wait time in cycles
   int m_own  = 0;
   int m_wait = 0;

   function automatic bit model_starving();
      return (m_wait == MAXW);
   endfunction

   always @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         m_own  <= 0;
         m_wait <= 0;
      end else begin
         if (m_own == 0) begin
            if (i_a_cyc && !model_starving()) m_own <= 1;
            else if (i_b_cyc && (!i_a_cyc || model_starving())) m_own <= 2;
         end else if (m_own == 1) begin
            if (!i_a_cyc) m_own <= 0;
         end else begin
            if (!i_b_cyc) m_own <= 0;
         end
         if (m_own == 2 || !i_b_cyc) m_wait <= 0;
         else m_wait <= (m_wait < MAXW) ? m_wait + 1 : MAXW;
      end
   end

   function automatic logic [70:0] model_out();
      logic oa, ob, we;
      logic [1:0] own;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [DW/8-1:0] sel;
      own = m_own[1:0];
      oa = (m_own == 1);
      ob = (m_own == 2);
      if (ob) begin
         we = i_b_we; addr = i_b_addr; data = i_b_data; sel = i_b_sel;
      end else begin
         we = i_a_we; addr = i_a_addr; data = i_a_data; sel = i_a_sel;
      end
      return {own, (oa & i_a_cyc) | (ob & i_b_cyc), (oa & i_a_stb) | (ob & i_b_stb),
              we, addr, data, sel,
              oa & i_ack, oa ? i_stall : 1'b1, oa & i_err,
              ob & i_ack, ob ? i_stall : 1'b1, ob & i_err};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_cyc(input logic a, input logic b);
      i_a_cyc = a; i_a_stb = a;
      i_b_cyc = b; i_b_stb = b;
   endtask

   // Idle/A-muxed bundle with the fixed directed-test field values
   function automatic logic [70:0] fixed_out(input logic [1:0] own, input logic cyc,
                                             input logic mux_b, input logic [5:0] resp);
      if (mux_b)
         return {own, cyc, cyc, 1'b0, 24'hB0B0B0, 32'hBBBB_0002, 4'h3, resp};
      return {own, cyc, cyc, 1'b1, 24'hA0A0A0, 32'hAAAA_0001, 4'hF, resp};
   endfunction

   typedef struct {
      logic [4:0] in;     // {a_cyc, b_cyc, ack, stall, err}
      logic [1:0] own;
      logic       cyc;
      logic       mux_b;
      logic [5:0] resp;   // {a_ack, a_stall, a_err, b_ack, b_stall, b_err}
   } vec_t;

   vec_t vecs[16];

   initial begin
      vecs[0]  = '{5'b10000, 2'b00, 1'b0, 1'b0, 6'b010010};
      vecs[1]  = '{5'b10010, 2'b01, 1'b1, 1'b0, 6'b010010};
      vecs[2]  = '{5'b10100, 2'b01, 1'b1, 1'b0, 6'b100010};
      vecs[3]  = '{5'b10001, 2'b01, 1'b1, 1'b0, 6'b001010};
      vecs[4]  = '{5'b00000, 2'b01, 1'b0, 1'b0, 6'b000010};
      vecs[5]  = '{5'b00100, 2'b00, 1'b0, 1'b0, 6'b010010};
      vecs[6]  = '{5'b11000, 2'b00, 1'b0, 1'b0, 6'b010010};
      vecs[7]  = '{5'b11000, 2'b01, 1'b1, 1'b0, 6'b000010};
      vecs[8]  = '{5'b01000, 2'b01, 1'b0, 1'b0, 6'b000010};
      vecs[9]  = '{5'b01000, 2'b00, 1'b0, 1'b0, 6'b010010};
      vecs[10] = '{5'b11100, 2'b10, 1'b1, 1'b1, 6'b010100};
      vecs[11] = '{5'b11001, 2'b10, 1'b1, 1'b1, 6'b010001};
      vecs[12] = '{5'b10000, 2'b10, 1'b0, 1'b1, 6'b010000};
      vecs[13] = '{5'b10100, 2'b00, 1'b0, 1'b0, 6'b010010};
      vecs[14] = '{5'b00000, 2'b01, 1'b0, 1'b0, 6'b000010};
      vecs[15] = '{5'b00000, 2'b00, 1'b0, 1'b0, 6'b010010};

      i_a_we = 1'b1; i_a_addr = 24'hA0A0A0; i_a_data = 32'hAAAA_0001; i_a_sel = 4'hF;
      i_b_we = 1'b0; i_b_addr = 24'hB0B0B0; i_b_data = 32'hBBBB_0002; i_b_sel = 4'h3;

      // Reset held with requests and responses active
      i_reset = 1'b1;
      set_cyc(1'b1, 1'b1);
      i_ack = 1'b1; i_stall = 1'b0; i_err = 1'b1;
      tick(); tick();
      @(negedge i_clk);
      check("reset_hold", w_act, fixed_out(2'b00, 1'b0, 1'b0, 6'b010010));
      tick();
      i_reset = 1'b0;
      set_cyc(1'b0, 1'b0);
      i_err = 1'b0;
      @(negedge i_clk);
      check("after_reset", w_act, fixed_out(2'b00, 1'b0, 1'b0, 6'b010010));
      tick();
      i_ack = 1'b0;

      for (int i = 0; i < 16; i++) begin
         set_cyc(vecs[i].in[4], vecs[i].in[3]);
         i_ack = vecs[i].in[2]; i_stall = vecs[i].in[1]; i_err = vecs[i].in[0];
         @(negedge i_clk);
         check($sformatf("vec%0d", i), w_act,
               fixed_out(vecs[i].own, vecs[i].cyc, vecs[i].mux_b, vecs[i].resp));
         tick();
      end

      // Starvation: A holds the bus while B keeps asking
      i_ack = 1'b0; i_stall = 1'b0; i_err = 1'b0;
      set_cyc(1'b1, 1'b1);
      for (int k = 1; k <= 70; k++) begin
         tick();
         if (k == 1)  check("grant_a_latency", o_owner, 2'b01);
         if (k == 62) check("starve_flag_62", dut.w_starve_flag, 1'b0);
         if (k == 63) check("starve_flag_63", dut.w_starve_flag, 1'b1);
         if (k == 70) check("no_preempt_70", {o_owner, o_b_stall}, {2'b01, 1'b1});
      end
      set_cyc(1'b0, 1'b1);
      tick();
      check("starve_idle", {o_owner, dut.w_starve_flag}, {2'b00, 1'b1});
      set_cyc(1'b1, 1'b1);
      tick();
      check("starve_grant_b", {o_owner, o_cyc, o_addr, o_a_stall}, {2'b10, 1'b1, 24'hB0B0B0, 1'b1});

      // B abort with outstanding requests, then a late ack
      set_cyc(1'b0, 1'b1);
      for (int k = 0; k < 3; k++) tick();
      check("starve_cnt_clear", dut.u_starve.r_cnt, 6'd0);
      set_cyc(1'b0, 1'b0);
      #1;
      check("b_abort", {o_owner, o_cyc, o_stb}, {2'b10, 1'b0, 1'b0});
      tick();
      i_ack = 1'b1;
      #1;
      check("late_ack", {o_owner, o_a_ack, o_b_ack}, {2'b00, 1'b0, 1'b0});
      i_ack = 1'b0;

      // Reset pulsed mid-burst while A owns
      set_cyc(1'b1, 1'b1);
      for (int k = 0; k < 4; k++) tick();
      check("burst_a", {o_owner, o_cyc}, {2'b01, 1'b1});
      #1;
      i_reset = 1'b1;
      #1;
      check("reset_mid", {o_owner, o_cyc, o_a_stall, o_b_stall, dut.u_starve.r_cnt},
            {2'b00, 1'b0, 1'b1, 1'b1, 6'd0});
      tick();
      i_reset = 1'b0;
      set_cyc(1'b0, 1'b0);
      tick();

      // Random traffic against the reference model
      for (int n = 0; n < 800; n++) begin
         if (i_a_cyc) i_a_cyc = ($urandom_range(0, (n < 400) ? 39 : 5) != 0);
         else         i_a_cyc = ($urandom_range(0, 2) == 0);
         if (i_b_cyc) i_b_cyc = ($urandom_range(0, 5) != 0);
         else         i_b_cyc = ($urandom_range(0, 2) == 0);
         i_a_stb  = i_a_cyc & $urandom_range(0, 1);
         i_b_stb  = i_b_cyc & $urandom_range(0, 1);
         i_a_we   = $urandom_range(0, 1);
         i_b_we   = $urandom_range(0, 1);
         i_a_addr = $urandom; i_b_addr = $urandom;
         i_a_data = $urandom; i_b_data = $urandom;
         i_a_sel  = $urandom; i_b_sel  = $urandom;
         i_ack    = $urandom_range(0, 1);
         i_stall  = $urandom_range(0, 1);
         i_err    = ($urandom_range(0, 9) == 0);
         @(negedge i_clk);
         check($sformatf("rand%0d", n), w_act, model_out());
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
